// File: rtl/pc_sequencer.sv
// Multi-phase program counter: phase counter, stall, async reset, jump/branch
// selection on the last phase; PC_CALL_STACK_EN adds a call/return stack.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH    = 16,
  parameter int unsigned          PHASES      = 5,
  parameter int unsigned          STATE_WIDTH = 3,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          STACK_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    address,
  input  logic                   rel,
  input  logic                   jump,
  input  logic                   beq,
  input  logic                   bne,
  input  logic                   compare,
  input  logic                   stall,
`ifdef PC_CALL_STACK_EN
  input  logic                   call,
  input  logic                   ret,
  output logic                   stack_err,
`endif
  output logic [PC_WIDTH-1:0]    pc,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   last_phase,
  output logic                   redirect
);

  if (PHASES < 2 || (64'd1 << STATE_WIDTH) < 64'(PHASES) || STACK_DEPTH < 1) begin : g_param_check
    $error("pc_sequencer: invalid PHASES/STATE_WIDTH/STACK_DEPTH");
  end

  localparam logic [STATE_WIDTH-1:0] LAST = STATE_WIDTH'(PHASES - 1);

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    pc_inc, pc_rel;
  logic                   redirect_q, redirect_d;
  logic                   take_branch;

  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign pc_rel      = pc_q + address;
  assign take_branch = (beq & compare) | (bne & ~compare);
  assign last_phase  = (state_q == LAST);

`ifdef PC_CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] stack_mem [(1 << IDX_W)];
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                err_q, err_d;
  logic                push;
  logic                stack_full, stack_empty;
  logic [IDX_W-1:0]    wr_idx, rd_idx;

  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign wr_idx      = IDX_W'(sp_q);
  assign rd_idx      = IDX_W'(sp_q - SP_W'(1));
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
`ifdef PC_CALL_STACK_EN
    sp_d       = sp_q;
    err_d      = err_q;
    push       = 1'b0;
`endif
    if (!stall) begin
      redirect_d = 1'b0;
      if (!last_phase) begin
        state_d = state_q + STATE_WIDTH'(1);
      end else begin
        state_d = '0;
        pc_d    = pc_inc;
`ifdef PC_CALL_STACK_EN
        // ret/call head the priority chain; the trailing else joins the jump test.
        if (ret) begin
          if (stack_empty) begin
            err_d = 1'b1;
          end else begin
            pc_d       = stack_mem[rd_idx];
            redirect_d = 1'b1;
            sp_d       = sp_q - SP_W'(1);
          end
        end else if (call) begin
          pc_d       = address;
          redirect_d = 1'b1;
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end else
`endif
        if (jump) begin
          pc_d       = address;
          redirect_d = 1'b1;
        end else if (take_branch) begin
          pc_d       = rel ? pc_rel : address;
          redirect_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entries above the pointer are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= pc_inc;
  end

  assign stack_err = err_q;
`endif

  assign pc       = pc_q;
  assign state    = state_q;
  assign redirect = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes expected pc updates from a
// behavioural model, monitor checks every cycle. Honours PC_CALL_STACK_EN.
module tb_pc_sequencer;
  localparam int unsigned     PW    = 16;
  localparam int unsigned     PH    = 5;
  localparam int unsigned     SW    = 3;
  localparam logic [PW-1:0]   RPC   = '0;
  localparam int unsigned     DEPTH = 2;
`ifdef PC_CALL_STACK_EN
  localparam bit HAS_STK = 1'b1;
`else
  localparam bit HAS_STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, rel, jump, beq, bne, compare, stall;
  logic [PW-1:0] address, pc;
  logic [SW-1:0] state;
  logic          last_phase, redirect;
`ifdef PC_CALL_STACK_EN
  logic          call, ret, stack_err;
`endif

  pc_sequencer #(
    .PC_WIDTH(PW), .PHASES(PH), .STATE_WIDTH(SW), .RESET_PC(RPC), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .rel(rel), .jump(jump),
    .beq(beq), .bne(bne), .compare(compare), .stall(stall),
`ifdef PC_CALL_STACK_EN
    .call(call), .ret(ret), .stack_err(stack_err),
`endif
    .pc(pc), .state(state), .last_phase(last_phase), .redirect(redirect)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] addr; logic rel, jump, beq, bne, cmp, call, ret; } ctrl_t;
  typedef struct { logic [PW-1:0] pc; logic red; logic err; } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [PW-1:0] m_pc;
  logic          m_err;
  logic [PW-1:0] m_stack[$];
  bit            fixed_junk = 1'b0;
  ctrl_t         junk_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t no_ctrl();
    ctrl_t c = '{default: '0};
    return c;
  endfunction

  function automatic ctrl_t rand_ctrl();
    ctrl_t c;
    case ($urandom_range(0, 4))
      0:       c.addr = 16'h0000;
      1:       c.addr = 16'hFFFF;
      2:       c.addr = 16'hFFFE;
      3:       c.addr = 16'h0001;
      default: c.addr = PW'($urandom);
    endcase
    c.rel  = 1'($urandom_range(0, 1));
    c.jump = ($urandom_range(0, 3) == 0);
    c.beq  = ($urandom_range(0, 2) == 0);
    c.bne  = ($urandom_range(0, 2) == 0);
    c.cmp  = 1'($urandom_range(0, 1));
    c.call = HAS_STK && ($urandom_range(0, 5) == 0);
    c.ret  = HAS_STK && ($urandom_range(0, 5) == 0);
    return c;
  endfunction

  task automatic apply(input ctrl_t c);
    address = c.addr; rel = c.rel; jump = c.jump;
    beq = c.beq; bne = c.bne; compare = c.cmp;
`ifdef PC_CALL_STACK_EN
    call = c.call; ret = c.ret;
`endif
  endtask

  // Reference: the pc an instruction's controls select, with a queue as the LIFO.
  task automatic model_update(input ctrl_t c);
    logic [PW-1:0] inc;
    exp_t e;
    inc   = m_pc + 1'b1;
    e.pc  = inc;
    e.red = 1'b1;
    if (c.ret) begin
      if (m_stack.size() > 0) e.pc = m_stack.pop_back();
      else begin e.red = 1'b0; m_err = 1'b1; end
    end else if (c.call) begin
      e.pc = c.addr;
      if (m_stack.size() < DEPTH) m_stack.push_back(inc);
      else m_err = 1'b1;
    end else if (c.jump) begin
      e.pc = c.addr;
    end else if ((c.beq && c.cmp) || (c.bne && !c.cmp)) begin
      e.pc = c.rel ? m_pc + c.addr : c.addr;
    end else begin
      e.red = 1'b0;
    end
    e.err = m_err;
    m_pc  = e.pc;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction: random stalls and junk controls in every phase; the
  // given controls are presented only on the unstalled last-phase cycle.
  task automatic do_instr(input ctrl_t c, input int last_stall);
    for (int p = 0; p < PH; p++) begin
      int ns;
      if (p == PH - 1)
        ns = (last_stall >= 0) ? last_stall : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      else
        ns = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      repeat (ns) begin
        apply(rand_ctrl());
        stall = 1'b1;
        cycle();
      end
      if (p == PH - 1) begin
        apply(c);
        model_update(c);
      end else begin
        apply(fixed_junk ? junk_c : rand_ctrl());
      end
      stall = 1'b0;
      cycle();
    end
  endtask

  initial begin : monitor
    int            exp_state;
    logic [PW-1:0] cur_pc;
    logic          cur_red, cur_err;
    bit            upd;
    exp_t          e;
    exp_state = 0; cur_pc = RPC; cur_red = 1'b0; cur_err = 1'b0; upd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_state = 0; cur_pc = RPC; cur_red = 1'b0; cur_err = 1'b0; upd = 1'b0;
      end else begin
        if (upd) begin
          upd = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got pc update %0h, expected a queued entry", pc);
          end else begin
            e = exp_q.pop_front();
            cur_pc = e.pc; cur_red = e.red; cur_err = e.err;
          end
        end
        chk("state", state, exp_state);
        chk("last_phase", last_phase, exp_state == PH - 1);
        chk("pc", pc, cur_pc);
        chk("redirect", redirect, cur_red);
`ifdef PC_CALL_STACK_EN
        chk("stack_err", stack_err, cur_err);
`endif
        if (!stall) begin
          if (exp_state == PH - 1) begin exp_state = 0; upd = 1'b1; end
          else begin exp_state++; cur_red = 1'b0; end
        end
      end
    end
  end

  initial begin : driver
    ctrl_t c;
    reset = 1'b1; stall = 1'b0; apply(no_ctrl());
    m_pc = RPC; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    do_instr(no_ctrl(), 0);
    c = no_ctrl(); c.jump = 1; c.addr = 16'h0010; do_instr(c, 0);
    c = no_ctrl(); c.beq = 1; c.cmp = 1; c.rel = 1; c.addr = 16'hFFFE; do_instr(c, 0);
    c = no_ctrl(); c.jump = 1; c.addr = 16'h0010; do_instr(c, 0);
    c = no_ctrl(); c.beq = 1; c.cmp = 0; c.rel = 1; c.addr = 16'hFFFE; do_instr(c, 0);
    c = no_ctrl(); c.jump = 1; c.addr = 16'hFFFF; do_instr(c, 0);
    do_instr(no_ctrl(), 0);
    junk_c = no_ctrl(); junk_c.jump = 1; junk_c.addr = 16'h1234; fixed_junk = 1'b1;
    do_instr(no_ctrl(), 0);
    fixed_junk = 1'b0;
    do_instr(no_ctrl(), 3);
    c = no_ctrl(); c.jump = 1; c.bne = 1; c.cmp = 0; c.rel = 1; c.addr = 16'h4321; do_instr(c, 0);
    c = no_ctrl(); c.beq = 1; c.cmp = 1; c.rel = 1; c.addr = 16'h0000; do_instr(c, 0);
    c = no_ctrl(); c.beq = 1; c.bne = 1; c.cmp = 0; c.addr = 16'h0ABC; do_instr(c, 0);

`ifdef PC_CALL_STACK_EN
    c = no_ctrl(); c.jump = 1; c.addr = 16'h0005; do_instr(c, 0);
    c = no_ctrl(); c.call = 1; c.addr = 16'h0100; do_instr(c, 0);
    c = no_ctrl(); c.call = 1; c.addr = 16'h0200; do_instr(c, 0);
    c = no_ctrl(); c.call = 1; c.addr = 16'h0300; do_instr(c, 0);
    c = no_ctrl(); c.ret = 1; do_instr(c, 0);
    c = no_ctrl(); c.ret = 1; do_instr(c, 0);
    c = no_ctrl(); c.ret = 1; do_instr(c, 0);
    chk("stack_err sticky", stack_err, 1);
    c = no_ctrl(); c.jump = 1; c.addr = 16'h0ABC; do_instr(c, 0);
`endif

    // Async reset in phase 3 must act before the next clock edge.
    apply(no_ctrl());
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1;
    chk("async reset pc", pc, RPC);
    chk("async reset state", state, 0);
    chk("async reset redirect", redirect, 0);
    m_pc = RPC; m_err = 1'b0; m_stack.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    repeat (300) do_instr(rand_ctrl(), -1);

    @(negedge clk);
    #1;
    chk("queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised multi-phase program counter for the multi-cycle CPU core.
- A phase counter steps 0..PHASES-1; the PC updates only on the last phase.
- At that update the PC takes one of: increment, absolute jump, PC-relative branch on beq/bne with compare, or optional call/return through an internal return-address stack.
- Adds stall and asynchronous reset over the fixed 5-phase, 16-bit counter it replaces.

Parameters:
PC_WIDTH, 16, width of pc and address in bits
PHASES, 5, phases per instruction (>=2); state counts 0..PHASES-1
STATE_WIDTH, 3, width of state; must satisfy 2^STATE_WIDTH >= PHASES
RESET_PC, 0, pc value loaded on reset
STACK_DEPTH, 4, return-stack entries (used only with PC_CALL_STACK_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
address  input  PC_WIDTH  jump/branch target (absolute) or offset (rel=1)
rel  input  1  1: branch target = pc + address (mod 2^PC_WIDTH); applies to beq/bne only
jump  input  1  unconditional absolute jump to address
beq  input  1  branch if compare=1
bne  input  1  branch if compare=0
compare  input  1  ALU equality result
stall  input  1  freeze state and pc this cycle
pc  output  PC_WIDTH  current program counter
state  output  STATE_WIDTH  current phase
last_phase  output  1  combinational: state==PHASES-1
redirect  output  1  registered: 1 for the one cycle after pc loaded a non-sequential target
call  input  1  (macro only) push pc+1, load address
ret  input  1  (macro only) pop top into pc
stack_err  output  1  (macro only) sticky overflow/underflow flag

Behaviour:
- Reset (async, any time incl. mid-instruction): pc=RESET_PC, state=0, redirect=0, stack pointer=0, stack_err=0. Takes effect immediately, not at the next edge.
- stall=1: state, pc, redirect and stack hold, regardless of phase. stall has priority over all control inputs.
- state<PHASES-1, no stall: state<=state+1, pc holds, redirect<=0.
- state==PHASES-1, no stall: state<=0. pc is selected by fixed priority:
  1. ret (macro)
  2. call (macro)
  3. jump -> address
  4. (beq&&compare) || (bne&&!compare) -> rel ? pc+address : address
  5. otherwise pc+1
- redirect<=1 when choice 1-4 was taken, else 0.
- Control inputs are sampled only on the last-phase edge; they are ignored in other phases.
- Arithmetic wraps modulo 2^PC_WIDTH: increment from all-ones gives 0; relative add drops the carry. Taken branch with rel=1, address=0 reloads the same pc with redirect=1.
- beq and bne both high: either condition true takes the branch.
- Latency: pc changes exactly PHASES unstalled cycles after the previous change.

Optional Feature:
- PC_CALL_STACK_EN defined:
  - call, ret and stack_err ports exist, plus a STACK_DEPTH x PC_WIDTH LIFO with pointer.
  - call: push pc+1 (wrapped), load address (always absolute).
  - ret: pop, load top entry.
  - call on full stack: pc still loads address, push is dropped, stack_err<=1.
  - ret on empty stack: pc<=pc+1, stack_err<=1.
  - call and ret together: ret wins, no push.
  - stack_err clears only on reset.
- Undefined: those ports and the stack are absent; priority begins at jump.

Test Plan:
- Reset, no stall, no controls, PHASES=5 -> state cycles 0,1,2,3,4,0; pc goes 0->1 on the edge leaving state 4; last_phase high only in state 4.
- pc=16'h0010, beq=1, compare=1, rel=1, address=16'hFFFE at last phase -> pc=16'h000E, redirect=1 for one cycle. Repeat with compare=0 -> pc=16'h0011, redirect=0.
- pc=16'hFFFF, no control at last phase -> pc=16'h0000. jump=1, address=16'h1234 asserted only in state 2 -> ignored, pc increments.
- stall=1 for 3 cycles while state=4 -> state and pc frozen; release -> update happens on the next edge. Async reset pulse mid-phase 3 -> pc=RESET_PC and state=0 before the next clk edge.
- PC_CALL_STACK_EN, STACK_DEPTH=2: call 0x100 from pc=5, then call 0x200 -> stack {6,0x101}; third call -> pc=address, stack_err=1; ret, ret -> pc 0x101 then 6; further ret -> pc+1, stack_err stays 1.
- jump=1, bne=1, compare=0, rel=1 together -> absolute address is taken (jump priority), redirect=1.
